text_cursor_ctrl: RTL

//  Text-terminal write controller between the PS/2 keyboard decode stage and the

---
 rtl/text_term_pkg.sv | 27 ++
 rtl/text_addr_calc.sv | 31 +++
 rtl/text_cursor_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/text_term_pkg.sv
`default_nettype none
//==============================================================================
// text_term_pkg - shared geometry, ASCII codes and FSM encoding for the text terminal. Rev 1.0
//==============================================================================
package text_term_pkg;

   localparam int COLS = 70;
   localparam int ROWS = 30;
   localparam int AW   = 12;

   localparam logic [7:0] ASCII_SPACE    = 8'h20;
   localparam logic [7:0] ASCII_CR       = 8'h0D;
   localparam logic [7:0] ASCII_BS       = 8'h08;
   localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
   localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

   localparam logic [1:0] ST_INIT_CLR = 2'd0;
   localparam logic [1:0] ST_IDLE     = 2'd1;
   localparam logic [1:0] ST_WRITE    = 2'd2;
   localparam logic [1:0] ST_LINE_CLR = 2'd3;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= ASCII_PRINT_LO) && (c <= ASCII_PRINT_HI);
   endfunction

endpackage
`default_nettype wire

// File: rtl/text_addr_calc.sv
`default_nettype none
//==============================================================================
// text_addr_calc - (row, col) to linear character RAM address, row*COLS as shift-add. Rev 1.0
//==============================================================================
module text_addr_calc #(
   parameter int COLS = text_term_pkg::COLS,
   parameter int AW   = text_term_pkg::AW
) (
   input  logic [4:0]    row,
   input  logic [6:0]    col,
   output logic [AW-1:0] addr
);

   localparam logic [31:0] COLS_BITS = COLS;

   logic [AW-1:0] row_mul;

   // One shifted copy of the row for every set bit of COLS.
   always_comb begin
      row_mul = '0;
      for (int i = 0; i < AW; i++) begin
         if (COLS_BITS[i]) begin
            row_mul = row_mul + (AW'(row) << i);
         end
      end
   end

   assign addr = row_mul + AW'(col);

endmodule
`default_nettype wire

// File: rtl/text_cursor_ctrl.sv
`default_nettype none
//==============================================================================
// text_cursor_ctrl - keyboard-to-character-RAM writer with cursor, wrap and scroll. Rev 1.0
//==============================================================================
module text_cursor_ctrl #(
   parameter int COLS = text_term_pkg::COLS,
   parameter int ROWS = text_term_pkg::ROWS,
   parameter int AW   = text_term_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_valid,
   input  logic [7:0]    key_ascii,
   output logic          key_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic [4:0]    cur_row,
   output logic [6:0]    cur_col,
   output logic [4:0]    top_row,
   output logic          busy
);
   import text_term_pkg::*;

   localparam logic [AW-1:0] CELLS    = AW'(COLS * ROWS);
   localparam logic [AW-1:0] LINE_LEN = AW'(COLS);
   localparam logic [4:0]    LAST_ROW = 5'(ROWS - 1);
   localparam logic [6:0]    LAST_COL = 7'(COLS - 1);

   logic [1:0]    state;
   logic [AW-1:0] clr_cnt;
   logic [4:0]    clr_row;
   logic          scroll_pend;

   logic [5:0]    row_sum;
   logic [4:0]    phys_row;
   logic [4:0]    phys_prev;
   logic [4:0]    next_top;
   logic [4:0]    calc_row;
   logic [6:0]    calc_col;
   logic [AW-1:0] calc_addr;
   logic          accept;
   logic          is_pr;
   logic          is_cr;
   logic          is_bs;
   logic          at_last_row;

   assign key_ready   = (state == ST_IDLE);
   assign busy        = (state == ST_INIT_CLR) || (state == ST_LINE_CLR);
   assign accept      = key_valid && key_ready;
   assign is_pr       = is_printable(key_ascii);
   assign is_cr       = (key_ascii == ASCII_CR);
   assign is_bs       = (key_ascii == ASCII_BS);
   assign at_last_row = (cur_row == LAST_ROW);

   // Logical-to-physical row through the rotating top pointer, wrapped by compare.
   assign row_sum   = {1'b0, top_row} + {1'b0, cur_row};
   assign phys_row  = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
   assign phys_prev = (phys_row == 5'd0) ? LAST_ROW : phys_row - 5'd1;
   assign next_top  = (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;

   always_comb begin
      calc_row = phys_row;
      calc_col = cur_col;
      if (state == ST_LINE_CLR) begin
         calc_row = clr_row;
         calc_col = clr_cnt[6:0];
      end else if (state == ST_WRITE) begin
         calc_row = clr_row;
         calc_col = 7'd0;
      end else if (is_cr) begin
         calc_row = top_row;
         calc_col = 7'd0;
      end else if (is_bs && (cur_col != 7'd0)) begin
         calc_col = cur_col - 7'd1;
      end else if (is_bs) begin
         calc_row = phys_prev;
         calc_col = LAST_COL;
      end
   end

   text_addr_calc #(
      .COLS (COLS),
      .AW   (AW)
   ) u_addr_calc (
      .row  (calc_row),
      .col  (calc_col),
      .addr (calc_addr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_INIT_CLR;
         clr_cnt     <= '0;
         clr_row     <= 5'd0;
         scroll_pend <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= ASCII_SPACE;
         cur_row     <= 5'd0;
         cur_col     <= 7'd0;
         top_row     <= 5'd0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            ST_INIT_CLR: begin
               if (clr_cnt == CELLS) begin
                  clr_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= clr_cnt;
                  wr_data <= ASCII_SPACE;
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  if (is_pr) begin
                     wr_en   <= 1'b1;
                     wr_addr <= calc_addr;
                     wr_data <= key_ascii;
                     state   <= ST_WRITE;
                     if (cur_col == LAST_COL) begin
                        cur_col <= 7'd0;
                        if (!at_last_row) begin
                           cur_row <= cur_row + 5'd1;
                        end else begin
                           top_row     <= next_top;
                           clr_row     <= top_row;
                           scroll_pend <= 1'b1;
                        end
                     end else begin
                        cur_col <= cur_col + 7'd1;
                     end
                  end else if (is_cr) begin
                     cur_col <= 7'd0;
                     if (!at_last_row) begin
                        cur_row <= cur_row + 5'd1;
                     end else begin
                        // The old top row becomes the new bottom; column 0 clears now.
                        top_row <= next_top;
                        clr_row <= top_row;
                        wr_en   <= 1'b1;
                        wr_addr <= calc_addr;
                        wr_data <= ASCII_SPACE;
                        clr_cnt <= AW'(1);
                        state   <= ST_LINE_CLR;
                     end
                  end else if (is_bs) begin
                     if (cur_col != 7'd0) begin
                        cur_col <= cur_col - 7'd1;
                        wr_en   <= 1'b1;
                        wr_addr <= calc_addr;
                        wr_data <= ASCII_SPACE;
                        state   <= ST_WRITE;
                     end else if (cur_row != 5'd0) begin
                        cur_row <= cur_row - 5'd1;
                        cur_col <= LAST_COL;
                        wr_en   <= 1'b1;
                        wr_addr <= calc_addr;
                        wr_data <= ASCII_SPACE;
                        state   <= ST_WRITE;
                     end
                  end
               end
            end
            ST_WRITE: begin
               if (scroll_pend) begin
                  scroll_pend <= 1'b0;
                  wr_en       <= 1'b1;
                  wr_addr     <= calc_addr;
                  wr_data     <= ASCII_SPACE;
                  clr_cnt     <= AW'(1);
                  state       <= ST_LINE_CLR;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_LINE_CLR: begin
               if (clr_cnt == LINE_LEN) begin
                  clr_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= calc_addr;
                  wr_data <= ASCII_SPACE;
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: state <= ST_INIT_CLR;
         endcase
      end
   end

endmodule
`default_nettype wire
